// File: rtl/mux_n_pipe_if.sv
// Valid/ready bus for mux_n_pipe: input beat (lanes + select) and output beat.
// master = producer/consumer side, slave = the selector pipe.
interface mux_n_pipe_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 32,
    parameter int unsigned SEL_W  = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        select;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;

    modport master (
        output in_valid, select, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, select, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/mux_n_pipe.sv
// Two-stage pipelined N:1 lane selector with valid/ready flow control.
// Stage 1 resolves the low select bits inside each group; stage 2 picks the group.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 32,
    parameter int unsigned GROUP  = 8,
    parameter int unsigned SEL_W  = 5
) (
    input  logic        clock,
    input  logic        reset,
    mux_n_pipe_if.slave bus
);
    localparam int unsigned LG   = $clog2(GROUP);
    localparam int unsigned NG   = NUM_IN / GROUP;
    localparam int unsigned HI_W = SEL_W - LG;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [LG-1:0]    w_lo;
    logic [HI_W-1:0]  w_hi;
    logic             w_err;
    logic [WIDTH-1:0] w_grp [NG];
    logic [WIDTH-1:0] w_pick;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_grp [NG];
    logic [HI_W-1:0]  r_s1_hi;
    logic             r_s1_err;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_err;

    // Bubble-collapsing: an empty downstream stage never blocks the one above it.
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = r_s1_valid && w_s2_adv;
    assign bus.in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign w_lo  = bus.select[LG-1:0];
    assign w_hi  = bus.select[SEL_W-1:LG];
    assign w_err = 32'(bus.select) >= NUM_IN;

    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            w_grp[g] = '0;
            for (int unsigned j = 0; j < GROUP; j++) begin
                if (w_lo == LG'(j)) begin
                    w_grp[g] = bus.in_data[(g*GROUP + j)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_pick = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (r_s1_hi == HI_W'(g)) begin
                w_pick = r_s1_grp[g];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_hi    <= '0;
            r_s1_err   <= 1'b0;
            for (int unsigned g = 0; g < NG; g++) begin
                r_s1_grp[g] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_hi    <= w_hi;
                r_s1_err   <= w_err;
                for (int unsigned g = 0; g < NG; g++) begin
                    r_s1_grp[g] <= w_grp[g];
                end
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= r_s1_err ? '0 : w_pick;
                r_s2_err   <= r_s1_err;
            end else if (bus.out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_err   = r_s2_err;
endmodule
